// File: rtl/drive_cmd_arbiter.sv
// Engine power sequencer and motion-command arbiter: hold-to-start power-up,
// drained mode changes, and a registered, conflict-masked command/barrier path.
module drive_cmd_arbiter #(
    parameter int HOLD_CYCLES = 100_000_000,
    parameter int GAP_CYCLES  = 1_000_000
) (
    input  logic       sys_clk,
    input  logic       rst_n,
    input  logic       power_on,
    input  logic       power_off,
    input  logic [2:0] mode_signal,
    input  logic [3:0] man_cmd,
    input  logic [3:0] semi_cmd,
    input  logic [3:0] auto_cmd,
    input  logic       auto_place,
    input  logic       auto_destroy,
    output logic [3:0] cmd,
    output logic       place_barrier,
    output logic       destroy_barrier,
    output logic       power_on_led,
    output logic [2:0] mode_led,
    output logic [2:0] grant,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int MAX_P = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
    localparam int CNT_W = (MAX_P > 1) ? $clog2(MAX_P) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_OFF    = 3'd0,
        S_ARMING = 3'd1,
        S_IDLE   = 3'd2,
        S_DRAIN  = 3'd3,
        S_GRANT  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0] gap_q, gap_d;
    logic [2:0]       target_q, target_d;
    logic [3:0]       cmd_q, cmd_d;
    logic             place_q, place_d;
    logic             destroy_q, destroy_d;
    logic             place_hist_q, destroy_hist_q;

    logic             mode_valid;
    logic             stay_grant;
    logic [3:0]       src_cmd;
    logic [3:0]       masked_cmd;
    logic             place_rise, destroy_rise;

    assign mode_valid = (mode_signal == 3'b001) || (mode_signal == 3'b010) ||
                        (mode_signal == 3'b100);

    always_comb begin
        state_d  = state_q;
        hold_d   = hold_q;
        gap_d    = gap_q;
        target_d = target_q;
        if (power_off) begin
            state_d = S_OFF;
            hold_d  = '0;
            gap_d   = '0;
        end else begin
            case (state_q)
                S_OFF: begin
                    if (power_on) begin
                        state_d = S_ARMING;
                        hold_d  = CNT_W'(1);
                    end
                end
                S_ARMING: begin
                    if (!power_on) begin
                        state_d = S_OFF;
                        hold_d  = '0;
                    end else if (hold_q == HOLD_LAST) begin
                        state_d = S_IDLE;
                        hold_d  = '0;
                    end else begin
                        hold_d = hold_q + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (mode_valid) begin
                        state_d  = S_DRAIN;
                        target_d = mode_signal;
                        gap_d    = '0;
                    end
                end
                S_DRAIN: begin
                    if (!mode_valid) begin
                        state_d = S_IDLE;
                        gap_d   = '0;
                    end else if (mode_signal != target_q) begin
                        target_d = mode_signal;
                        gap_d    = '0;
                    end else if (gap_q == GAP_LAST) begin
                        state_d = S_GRANT;
                        gap_d   = '0;
                    end else begin
                        gap_d = gap_q + 1'b1;
                    end
                end
                S_GRANT: begin
                    if (!mode_valid) begin
                        state_d = S_IDLE;
                    end else if (mode_signal != target_q) begin
                        state_d  = S_DRAIN;
                        target_d = mode_signal;
                        gap_d    = '0;
                    end
                end
                default: state_d = S_OFF;
            endcase
        end
    end

    // Forward only while GRANT persists across the edge, so cmd is already 0
    // in the first cycle after any exit (mode change, invalid mode or stop).
    assign stay_grant = (state_q == S_GRANT) && (state_d == S_GRANT);

    always_comb begin
        src_cmd = 4'b0000;
        case (target_q)
            3'b001:  src_cmd = man_cmd;
            3'b010:  src_cmd = semi_cmd;
            3'b100:  src_cmd = auto_cmd;
            default: src_cmd = 4'b0000;
        endcase
        masked_cmd = src_cmd;
        if (src_cmd[3] && src_cmd[2]) masked_cmd[3:2] = 2'b00;
        if (src_cmd[1] && src_cmd[0]) masked_cmd[1:0] = 2'b00;
        cmd_d = stay_grant ? masked_cmd : 4'b0000;
    end

    assign place_rise   = auto_place && !place_hist_q;
    assign destroy_rise = auto_destroy && !destroy_hist_q;
    // Simultaneous place and destroy edges are ambiguous, so neither fires.
    assign place_d   = stay_grant && (target_q == 3'b100) && place_rise && !destroy_rise;
    assign destroy_d = stay_grant && (target_q == 3'b100) && destroy_rise && !place_rise;

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_OFF;
            hold_q         <= '0;
            gap_q          <= '0;
            target_q       <= 3'b000;
            cmd_q          <= 4'b0000;
            place_q        <= 1'b0;
            destroy_q      <= 1'b0;
            place_hist_q   <= 1'b0;
            destroy_hist_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_q         <= hold_d;
            gap_q          <= gap_d;
            target_q       <= target_d;
            cmd_q          <= cmd_d;
            place_q        <= place_d;
            destroy_q      <= destroy_d;
            place_hist_q   <= auto_place;
            destroy_hist_q <= auto_destroy;
        end
    end

    assign cmd             = cmd_q;
    assign place_barrier   = place_q;
    assign destroy_barrier = destroy_q;
    assign power_on_led    = (state_q == S_IDLE) || (state_q == S_DRAIN) || (state_q == S_GRANT);
    assign busy            = (state_q == S_ARMING) || (state_q == S_DRAIN);
    assign mode_led        = ((state_q == S_DRAIN) || (state_q == S_GRANT)) ? target_q : 3'b000;
    assign grant           = (state_q == S_GRANT) ? target_q : 3'b000;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_drive_cmd_arbiter.sv
// Directed bench for drive_cmd_arbiter: per-cycle vector table plus
// hand-written power-up and reset-during-arming sequences.
module tb_drive_cmd_arbiter;

    localparam logic [2:0] S_OFF   = 3'd0;
    localparam logic [2:0] S_ARM   = 3'd1;
    localparam logic [2:0] S_IDLE  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_GRANT = 3'd4;

    logic       sys_clk;
    logic       rst_n;
    logic       power_on;
    logic       power_off;
    logic [2:0] mode_signal;
    logic [3:0] man_cmd;
    logic [3:0] semi_cmd;
    logic [3:0] auto_cmd;
    logic       auto_place;
    logic       auto_destroy;
    logic [3:0] cmd;
    logic       place_barrier;
    logic       destroy_barrier;
    logic       power_on_led;
    logic [2:0] mode_led;
    logic [2:0] grant;
    logic       busy;
    logic [2:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic       pon;
        logic       poff;
        logic [2:0] mode;
        logic [3:0] man;
        logic [3:0] semi;
        logic [3:0] auto_c;
        logic       ap;
        logic       ad;
        logic [2:0] e_st;
        logic [2:0] e_mled;
        logic [3:0] e_cmd;
        logic       e_pb;
        logic       e_db;
    } vec_t;

    vec_t vec_q[$];

    drive_cmd_arbiter #(
        .HOLD_CYCLES(8),
        .GAP_CYCLES (4)
    ) dut (
        .sys_clk        (sys_clk),
        .rst_n          (rst_n),
        .power_on       (power_on),
        .power_off      (power_off),
        .mode_signal    (mode_signal),
        .man_cmd        (man_cmd),
        .semi_cmd       (semi_cmd),
        .auto_cmd       (auto_cmd),
        .auto_place     (auto_place),
        .auto_destroy   (auto_destroy),
        .cmd            (cmd),
        .place_barrier  (place_barrier),
        .destroy_barrier(destroy_barrier),
        .power_on_led   (power_on_led),
        .mode_led       (mode_led),
        .grant          (grant),
        .busy           (busy),
        .dbg_state      (dbg_state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic chk(input string name, input int idx, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s @%0d got=%0d exp=%0d", name, idx, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk);
        @(negedge sys_clk);
    endtask

    // Checks every output against an expected state and latched mode; the
    // LED/busy/grant values follow directly from the state definition.
    task automatic chk_all(input int idx, input logic [2:0] st, input logic [2:0] mled,
                           input logic [3:0] c, input logic pb, input logic db);
        logic [2:0] m;
        m = ((st == S_DRAIN) || (st == S_GRANT)) ? mled : 3'b000;
        chk("state", idx, dbg_state, st);
        chk("cmd", idx, cmd, c);
        chk("place", idx, place_barrier, pb);
        chk("destroy", idx, destroy_barrier, db);
        chk("led", idx, power_on_led, (st == S_IDLE) || (st == S_DRAIN) || (st == S_GRANT));
        chk("busy", idx, busy, (st == S_ARM) || (st == S_DRAIN));
        chk("mode_led", idx, mode_led, m);
        chk("grant", idx, grant, (st == S_GRANT) ? mled : 3'b000);
    endtask

    task automatic row(input logic pon, input logic poff, input logic [2:0] mode,
                       input logic [3:0] man, input logic [3:0] semi, input logic [3:0] auto_c,
                       input logic ap, input logic ad, input logic [2:0] e_st,
                       input logic [2:0] e_mled, input logic [3:0] e_cmd,
                       input logic e_pb, input logic e_db);
        vec_t v;
        v.pon = pon; v.poff = poff; v.mode = mode; v.man = man; v.semi = semi;
        v.auto_c = auto_c; v.ap = ap; v.ad = ad; v.e_st = e_st; v.e_mled = e_mled;
        v.e_cmd = e_cmd; v.e_pb = e_pb; v.e_db = e_db;
        vec_q.push_back(v);
    endtask

    initial begin
        // Power-up: a 7-sample attempt fails, then 8 samples reach IDLE.
        for (int i = 0; i < 7; i++) row(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 0, 0, S_ARM, 3'b000, 4'h0, 0, 0);
        row(0, 0, 3'b000, 4'h0, 4'h0, 4'h0, 0, 0, S_OFF, 3'b000, 4'h0, 0, 0);
        for (int i = 1; i <= 8; i++)
            row(1, 0, 3'b000, 4'h0, 4'h0, 4'h0, 0, 0, (i == 8) ? S_IDLE : S_ARM, 3'b000, 4'h0, 0, 0);
        // Manual grant with a 4-cycle drain; semi request must never leak.
        for (int i = 0; i < 4; i++) row(0, 0, 3'b001, 4'b0001, 4'b1000, 4'h0, 0, 0, S_DRAIN, 3'b001, 4'h0, 0, 0);
        row(0, 0, 3'b001, 4'b0001, 4'b1000, 4'h0, 0, 0, S_GRANT, 3'b001, 4'b0000, 0, 0);
        row(0, 0, 3'b001, 4'b0001, 4'b1000, 4'h0, 0, 0, S_GRANT, 3'b001, 4'b0001, 0, 0);
        row(0, 0, 3'b001, 4'b0001, 4'b1000, 4'h0, 0, 0, S_GRANT, 3'b001, 4'b0001, 0, 0);
        row(0, 0, 3'b001, 4'b0010, 4'b1000, 4'h0, 0, 0, S_GRANT, 3'b001, 4'b0010, 0, 0);
        // Conflict masking.
        row(0, 0, 3'b001, 4'b1111, 4'b1000, 4'h0, 0, 0, S_GRANT, 3'b001, 4'b0000, 0, 0);
        row(0, 0, 3'b001, 4'b1101, 4'b1000, 4'h0, 0, 0, S_GRANT, 3'b001, 4'b0001, 0, 0);
        row(0, 0, 3'b001, 4'b1110, 4'b1000, 4'h0, 0, 0, S_GRANT, 3'b001, 4'b0010, 0, 0);
        row(0, 0, 3'b001, 4'b0011, 4'b1000, 4'h0, 0, 0, S_GRANT, 3'b001, 4'b0000, 0, 0);
        row(0, 0, 3'b001, 4'b1010, 4'b1000, 4'h0, 0, 0, S_GRANT, 3'b001, 4'b1010, 0, 0);
        // Switch to semi-auto: cmd drops at once, then 4-cycle drain.
        for (int i = 0; i < 4; i++) row(0, 0, 3'b010, 4'b1010, 4'b0100, 4'h0, 0, 0, S_DRAIN, 3'b010, 4'h0, 0, 0);
        row(0, 0, 3'b010, 4'b1010, 4'b0100, 4'h0, 0, 0, S_GRANT, 3'b010, 4'b0000, 0, 0);
        row(0, 0, 3'b010, 4'b1010, 4'b0100, 4'h0, 0, 0, S_GRANT, 3'b010, 4'b0100, 0, 0);
        // To manual, then auto mid-drain: the count restarts.
        for (int i = 0; i < 2; i++) row(0, 0, 3'b001, 4'b1010, 4'b0100, 4'b1001, 0, 0, S_DRAIN, 3'b001, 4'h0, 0, 0);
        for (int i = 0; i < 4; i++) row(0, 0, 3'b100, 4'b1010, 4'b0100, 4'b1001, 0, 0, S_DRAIN, 3'b100, 4'h0, 0, 0);
        row(0, 0, 3'b100, 4'b1010, 4'b0100, 4'b1001, 0, 0, S_GRANT, 3'b100, 4'b0000, 0, 0);
        row(0, 0, 3'b100, 4'b1010, 4'b0100, 4'b1001, 0, 0, S_GRANT, 3'b100, 4'b1001, 0, 0);
        // Barrier pulses in auto grant.
        row(0, 0, 3'b100, 4'b1010, 4'b0100, 4'b1001, 1, 0, S_GRANT, 3'b100, 4'b1001, 1, 0);
        for (int i = 0; i < 4; i++) row(0, 0, 3'b100, 4'b1010, 4'b0100, 4'b1001, 1, 0, S_GRANT, 3'b100, 4'b1001, 0, 0);
        row(0, 0, 3'b100, 4'b1010, 4'b0100, 4'b1001, 0, 0, S_GRANT, 3'b100, 4'b1001, 0, 0);
        row(0, 0, 3'b100, 4'b1010, 4'b0100, 4'b1001, 1, 1, S_GRANT, 3'b100, 4'b1001, 0, 0);
        row(0, 0, 3'b100, 4'b1010, 4'b0100, 4'b1001, 1, 1, S_GRANT, 3'b100, 4'b1001, 0, 0);
        row(0, 0, 3'b100, 4'b1010, 4'b0100, 4'b1001, 0, 0, S_GRANT, 3'b100, 4'b1001, 0, 0);
        row(0, 0, 3'b100, 4'b1010, 4'b0100, 4'b1001, 0, 1, S_GRANT, 3'b100, 4'b1001, 0, 1);
        row(0, 0, 3'b100, 4'b1010, 4'b0100, 4'b1001, 0, 1, S_GRANT, 3'b100, 4'b1001, 0, 0);
        row(0, 0, 3'b100, 4'b1010, 4'b0100, 4'b1001, 0, 0, S_GRANT, 3'b100, 4'b1001, 0, 0);
        // Invalid mode returns to IDLE with power still on.
        row(0, 0, 3'b011, 4'b1010, 4'b0100, 4'b1001, 0, 0, S_IDLE, 3'b000, 4'h0, 0, 0);
        // Manual grant again; a place edge there must not pulse.
        for (int i = 0; i < 4; i++) row(0, 0, 3'b001, 4'b1010, 4'b0100, 4'b1001, 0, 0, S_DRAIN, 3'b001, 4'h0, 0, 0);
        row(0, 0, 3'b001, 4'b1010, 4'b0100, 4'b1001, 0, 0, S_GRANT, 3'b001, 4'b0000, 0, 0);
        row(0, 0, 3'b001, 4'b1010, 4'b0100, 4'b1001, 0, 0, S_GRANT, 3'b001, 4'b1010, 0, 0);
        row(0, 0, 3'b001, 4'b1010, 4'b0100, 4'b1001, 1, 0, S_GRANT, 3'b001, 4'b1010, 0, 0);
        row(0, 0, 3'b001, 4'b1010, 4'b0100, 4'b1001, 0, 0, S_GRANT, 3'b001, 4'b1010, 0, 0);
        // power_off beats power_on: OFF next cycle with every output 0.
        row(1, 1, 3'b001, 4'b1010, 4'b0100, 4'b1001, 0, 0, S_OFF, 3'b000, 4'h0, 0, 0);
        row(0, 0, 3'b001, 4'b1010, 4'b0100, 4'b1001, 0, 0, S_OFF, 3'b000, 4'h0, 0, 0);

        rst_n = 1'b0; power_on = 1'b0; power_off = 1'b0; mode_signal = 3'b000;
        man_cmd = 4'h0; semi_cmd = 4'h0; auto_cmd = 4'h0; auto_place = 1'b0; auto_destroy = 1'b0;
        repeat (2) @(negedge sys_clk);
        chk_all(-1, S_OFF, 3'b000, 4'h0, 0, 0);
        rst_n = 1'b1;

        for (int i = 0; i < vec_q.size(); i++) begin
            power_on = vec_q[i].pon; power_off = vec_q[i].poff; mode_signal = vec_q[i].mode;
            man_cmd = vec_q[i].man; semi_cmd = vec_q[i].semi; auto_cmd = vec_q[i].auto_c;
            auto_place = vec_q[i].ap; auto_destroy = vec_q[i].ad;
            tick();
            chk_all(i, vec_q[i].e_st, vec_q[i].e_mled, vec_q[i].e_cmd, vec_q[i].e_pb, vec_q[i].e_db);
        end

        // Reset mid-ARMING: outputs clear immediately, and the hold restarts.
        power_on = 1'b1; power_off = 1'b0; mode_signal = 3'b000;
        auto_place = 1'b0; auto_destroy = 1'b0;
        repeat (3) tick();
        chk_all(1000, S_ARM, 3'b000, 4'h0, 0, 0);
        #2 rst_n = 1'b0;
        #1 chk_all(1001, S_OFF, 3'b000, 4'h0, 0, 0);
        @(negedge sys_clk);
        chk_all(1002, S_OFF, 3'b000, 4'h0, 0, 0);
        rst_n = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            tick();
            chk_all(1002 + i, (i == 8) ? S_IDLE : S_ARM, 3'b000, 4'h0, 0, 0);
        end
        power_on = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
